conv2_quad_mac: RTL and testbench
=================================

# conv2_quad_mac

Responder side of the conv2 convolver handshake. It accepts a 6×6 input-map tile (`im`) and a 5×5 kernel (`iw`) from the conv2 controller. It computes the four overlapping 5×5 dot products that make up a 2×2 output patch, using a sequential 4-lane MAC. The results are returned as sign-magnitude halfwords (`conv2_num1..4`) with a level-held `convResVld`, which the controller samples and adds into its accumulators.

## Interface
Parameters:
- `DATA_SIZE`, 8: element width, sign-magnitude (bit 7 = sign, bits 6:0 = magnitude, Q0.6).
- `K`, 5: kernel side.
- `MAP`, 6: tile side (`K`+1).
- `ACC_W`, 20: internal two's-complement accumulator width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `imVld`, in, 1: level; `im` is valid and held while high.
- `iwVld`, in, 1: level; `iw` is valid and held while high.
- `im`, in, 288: pixel (r,c) at bits [8*(6r+c)+7 : 8*(6r+c)].
- `iw`, in, 200: weight (i,j) at bits [8*(5i+j)+7 : 8*(5i+j)].
- `convResVld`, out, 1: level; `conv2_num1..4` are valid and stable while high.
- `conv2_num1`, out, 16: result for window origin (0,0), sign-magnitude Q0.11.
- `conv2_num2`, out, 16: result for window origin (0,1).
- `conv2_num3`, out, 16: result for window origin (1,0).
- `conv2_num4`, out, 16: result for window origin (1,1).
- `busy`, out, 1: high in MAC and PACK.

## Operation
- **States:** IDLE, MAC, PACK, DONE.
- **IDLE:**
  - If `imVld & iwVld` is sampled high, capture `im` and `iw` into internal registers, clear the 4 accumulators and tap counter t=0, and go to MAC.
  - Otherwise stay in IDLE.
- **MAC:** one tap per cycle, t = 5i+j, for t = 0..24.
  - For lane L with origin (dr,dc), the pixel is p = im(i+dr, j+dc) and the weight is w = iw(i,j).
  - Product magnitude = (p[6:0]*w[6:0]) >> 1 (13 bits, Q0.11, truncated).
  - Product sign = p[7]^w[7]. A zero magnitude contributes 0 regardless of sign.
  - acc_L += ±magnitude (signed, `ACC_W` bits; no overflow is possible).
  - After t=24 go to PACK.
- **PACK:** convert each acc_L to sign-magnitude.
  - Sign = acc<0.
  - Magnitude = min(|acc|, 0x7FFF); saturate, never wrap.
  - acc==0 outputs 0x0000 (never negative zero).
  - Register the results into `conv2_num1..4`, set `convResVld`=1, go to DONE.
- **DONE:**
  - Hold outputs and `convResVld`=1 while `imVld` stays high.
  - When `imVld`=0, clear `convResVld` and go to IDLE. `conv2_num*` keep their last values.
  - `iwVld` falling in DONE (the last tile of a channel) does not abort. Exit still requires `imVld`=0. Both may fall together.
- **Abort:** if `imVld` or `iwVld` is sampled low during MAC or PACK, return to IDLE. `convResVld` stays 0 and outputs are unchanged.
- **Input changes:** changes on `im`/`iw` after capture are ignored until the next IDLE capture.
- **No re-trigger:** a new computation never starts in DONE. `imVld` must first be seen low.

## Timing
- **Reset values:** `convResVld`=0, `conv2_num1..4`=0x0000, `busy`=0, state=IDLE, accumulators=0, t=0.
- **Reset mid-operation:** immediate asynchronous return to these values. Nothing is produced until a fresh capture.
- **Latency:** capture at edge T; MAC taps at edges T+1..T+25; PACK at edge T+26. `convResVld` reads 1 after edge T+26.
- **Release:** `imVld` sampled 0 at edge D clears `convResVld` after edge D.
- **Re-capture:** the earliest re-capture is the first edge at which IDLE samples `imVld & iwVld`. With the controller's 3-cycle map reload this is ≥ D+3.
- **Throughput:** one tile per 27 cycles plus handshake overhead.
- **Output stability:** outputs change only in PACK and on reset. They are stable for the entire time `convResVld` is high, covering the controller's 3-cycle read.

## Test plan
- **Window mapping:** pixel(r,c)=6r+c (positive); weight(2,2)=0x40, all others 0x00. Expect `num1`=0x01C0, `num2`=0x01E0, `num3`=0x0280, `num4`=0x02A0, with `convResVld` rising 26 cycles after capture.
- **Sign and saturation:**
  - All pixels 0x40, all weights 0x08 → all outputs 0x1900.
  - Weights 0x88 → 0x9900.
  - Weights 0x40 → 0x7FFF (saturated).
- **Cancellation:** pixels 0x40; taps 0..11 = 0x08, taps 12..23 = 0x88, tap 24 = 0x00. Expect all outputs 0x0000 (not 0x8000).
- **Handshake hold and release:**
  - Hold `imVld` 10 cycles after `convResVld` → outputs stable and no restart.
  - Drop `imVld` → `convResVld`=0 next edge.
  - Raise `imVld` with a new tile while `iwVld` is held → new result 26 cycles later.
  - Drop `imVld` and `iwVld` together → clean return to IDLE.
- **Abort:** drop `imVld` at t=10 → `convResVld` never asserts and previous outputs are retained.
- **Reset mid-MAC:** assert `rst` at t=10 → all outputs 0 immediately; the next full handshake yields the correct result.

Source files
------------

// File: rtl/conv2_quad_mac.sv
// conv2_quad_mac: responder side of the conv2 handshake. A four-lane sequential MAC
// convolves a 6x6 tile with a 5x5 kernel and returns a 2x2 sign-magnitude patch.
module conv2_quad_mac #(
  parameter int DATA_SIZE = 8,
  parameter int K         = 5,
  parameter int MAP       = 6,
  parameter int ACC_W     = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         imVld,
  input  logic                         iwVld,
  input  logic [MAP*MAP*DATA_SIZE-1:0] im,
  input  logic [K*K*DATA_SIZE-1:0]     iw,
  output logic                         convResVld,
  output logic [15:0]                  conv2_num1,
  output logic [15:0]                  conv2_num2,
  output logic [15:0]                  conv2_num3,
  output logic [15:0]                  conv2_num4,
  output logic                         busy
);
  // state | meaning
  // IDLE  | waiting for imVld & iwVld; capture tile and kernel
  // MAC   | one kernel tap per cycle into all four lane accumulators
  // PACK  | accumulators -> saturated sign-magnitude, raise convResVld
  // DONE  | results held until the controller drops imVld

  localparam int MAG_W  = DATA_SIZE - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int CNT_W  = $clog2(K);
  localparam int PIX_IW = $clog2(MAP * MAP);
  localparam int WGT_IW = $clog2(K * K);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(K - 1);
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'(32'h7FFF);

  typedef enum logic [1:0] {IDLE, MAC, PACK, DONE} state_t;

  state_t state_q, state_d;

  logic [MAP*MAP*DATA_SIZE-1:0] im_q;
  logic [K*K*DATA_SIZE-1:0]     iw_q;
  logic [CNT_W-1:0]             row_q, col_q;
  logic [3:0][ACC_W-1:0]        acc_q;
  logic [3:0][ACC_W-1:0]        term;

  logic [DATA_SIZE-1:0] im_el [MAP*MAP];
  logic [DATA_SIZE-1:0] iw_el [K*K];
  logic [WGT_IW-1:0]    w_idx;
  logic [DATA_SIZE-1:0] w_cur;
  logic                 go;
  logic                 last_tap;

  assign go       = imVld & iwVld;
  assign last_tap = (row_q == LAST) && (col_q == LAST);
  assign busy     = (state_q == MAC) || (state_q == PACK);

  for (genvar n = 0; n < MAP*MAP; n++) begin : g_im
    assign im_el[n] = im_q[DATA_SIZE*n +: DATA_SIZE];
  end

  for (genvar n = 0; n < K*K; n++) begin : g_iw
    assign iw_el[n] = iw_q[DATA_SIZE*n +: DATA_SIZE];
  end

  assign w_idx = WGT_IW'(K * int'(row_q) + int'(col_q));
  assign w_cur = iw_el[w_idx];

  // Lane l covers window origin (l/2, l%2); all lanes share the current weight.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    localparam int DR = l / 2;
    localparam int DC = l % 2;
    logic [PIX_IW-1:0]    p_idx;
    logic [DATA_SIZE-1:0] p_cur;
    logic [PROD_W-1:0]    prod;
    logic [ACC_W-1:0]     mag;

    assign p_idx   = PIX_IW'(MAP * (int'(row_q) + DR) + int'(col_q) + DC);
    assign p_cur   = im_el[p_idx];
    assign prod    = PROD_W'(p_cur[MAG_W-1:0]) * PROD_W'(w_cur[MAG_W-1:0]);
    assign mag     = ACC_W'(prod >> 1);
    assign term[l] = (p_cur[DATA_SIZE-1] ^ w_cur[DATA_SIZE-1]) ? -mag : mag;
  end

  // Zero accumulator yields +0 because the sign bit only sets for negative values.
  function automatic logic [15:0] to_sm(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] m;
    m = a[ACC_W-1] ? -a : a;
    if (m > MAG_MAX) m = MAG_MAX;
    return {a[ACC_W-1], m[14:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = MAC;
      MAC: begin
        if (!go)           state_d = IDLE;
        else if (last_tap) state_d = PACK;
      end
      PACK:    state_d = go ? DONE : IDLE;
      DONE:    if (!imVld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q       <= '0;
      iw_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      convResVld <= 1'b0;
      conv2_num1 <= '0;
      conv2_num2 <= '0;
      conv2_num3 <= '0;
      conv2_num4 <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            im_q  <= im;
            iw_q  <= iw;
            acc_q <= '0;
            row_q <= '0;
            col_q <= '0;
          end
        end
        MAC: begin
          if (go) begin
            acc_q[0] <= acc_q[0] + term[0];
            acc_q[1] <= acc_q[1] + term[1];
            acc_q[2] <= acc_q[2] + term[2];
            acc_q[3] <= acc_q[3] + term[3];
            if (col_q == LAST) begin
              col_q <= '0;
              row_q <= row_q + CNT_W'(1);
            end else begin
              col_q <= col_q + CNT_W'(1);
            end
          end
        end
        PACK: begin
          if (go) begin
            conv2_num1 <= to_sm(acc_q[0]);
            conv2_num2 <= to_sm(acc_q[1]);
            conv2_num3 <= to_sm(acc_q[2]);
            conv2_num4 <= to_sm(acc_q[3]);
            convResVld <= 1'b1;
          end
        end
        DONE: begin
          if (!imVld) convResVld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_quad_mac.sv
// Directed bench for conv2_quad_mac: vector table of tiles with hand-computed
// patches, plus hold/release, abort and mid-MAC reset sequences.
module tb_conv2_quad_mac;
  logic         clk = 1'b0;
  logic         rst;
  logic         imVld, iwVld;
  logic [287:0] im;
  logic [199:0] iw;
  logic         convResVld;
  logic [15:0]  conv2_num1, conv2_num2, conv2_num3, conv2_num4;
  logic         busy;

  always #5 clk = ~clk;

  conv2_quad_mac dut (
    .clk(clk), .rst(rst), .imVld(imVld), .iwVld(iwVld), .im(im), .iw(iw),
    .convResVld(convResVld), .conv2_num1(conv2_num1), .conv2_num2(conv2_num2),
    .conv2_num3(conv2_num3), .conv2_num4(conv2_num4), .busy(busy)
  );

  typedef struct {
    logic [287:0] im;
    logic [199:0] iw;
    logic [15:0]  e1, e2, e3, e4;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [287:0] im_const(input logic [7:0] v);
    logic [287:0] r = '0;
    for (int n = 35; n >= 0; n--) r = {r[279:0], v};
    return r;
  endfunction

  function automatic logic [287:0] im_ramp();
    logic [287:0] r = '0;
    for (int n = 35; n >= 0; n--) r = {r[279:0], 8'(n)};
    return r;
  endfunction

  function automatic logic [199:0] iw_const(input logic [7:0] v);
    logic [199:0] r = '0;
    for (int n = 24; n >= 0; n--) r = {r[191:0], v};
    return r;
  endfunction

  function automatic logic [199:0] iw_single(input int tap, input logic [7:0] v);
    logic [199:0] r = '0;
    for (int n = 24; n >= 0; n--) r = {r[191:0], (n == tap) ? v : 8'h00};
    return r;
  endfunction

  function automatic logic [199:0] iw_cancel();
    logic [199:0] r = '0;
    for (int n = 24; n >= 0; n--)
      r = {r[191:0], (n < 12) ? 8'h08 : ((n < 24) ? 8'h88 : 8'h00)};
    return r;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] e3, input logic [15:0] e4);
    check({tag, "_num1"}, int'(conv2_num1), int'(e1));
    check({tag, "_num2"}, int'(conv2_num2), int'(e2));
    check({tag, "_num3"}, int'(conv2_num3), int'(e3));
    check({tag, "_num4"}, int'(conv2_num4), int'(e4));
  endtask

  // Drives the handshake high and returns just after the capture edge.
  task automatic begin_tile(input logic [287:0] m, input logic [199:0] w);
    @(negedge clk);
    im = m; iw = w; imVld = 1'b1; iwVld = 1'b1;
    @(posedge clk); #1;
    check("busy_after_capture", int'(busy), 1);
  endtask

  task automatic start_tile(input string tag, input logic [287:0] m, input logic [199:0] w);
    int lat;
    begin_tile(m, w);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!convResVld && lat < 60);
    check({tag, "_latency"}, lat, 26);
  endtask

  task automatic hold(input string tag, input int cycles, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      check({tag, "_vld"}, int'(convResVld), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check_outs(tag, e1, e2, e3, e4);
    end
  endtask

  task automatic release_vld(input string tag, input logic drop_iw);
    @(negedge clk);
    imVld = 1'b0;
    if (drop_iw) iwVld = 1'b0;
    @(posedge clk); #1;
    check({tag, "_vld_clear"}, int'(convResVld), 0);
    check({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; imVld = 1'b0; iwVld = 1'b0; im = '0; iw = '0;

    vecs[0] = '{im_ramp(),       iw_single(12, 8'h40), 16'h01C0, 16'h01E0, 16'h0280, 16'h02A0};
    vecs[1] = '{im_const(8'h40), iw_const(8'h08),      16'h1900, 16'h1900, 16'h1900, 16'h1900};
    vecs[2] = '{im_const(8'h40), iw_const(8'h88),      16'h9900, 16'h9900, 16'h9900, 16'h9900};
    vecs[3] = '{im_const(8'h40), iw_const(8'h40),      16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[4] = '{im_const(8'h40), iw_cancel(),          16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{im_const(8'hC0), iw_single(24, 8'h40), 16'h8800, 16'h8800, 16'h8800, 16'h8800};
    vecs[6] = '{im_const(8'h80), iw_const(8'h88),      16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{im_const(8'h7F), iw_single(0, 8'hFF),  16'h9F80, 16'h9F80, 16'h9F80, 16'h9F80};
    vecs[8] = '{im_ramp(),       iw_single(0, 8'h03),  16'h0000, 16'h0001, 16'h0009, 16'h000A};
    vecs[9] = '{im_const(8'hC0), iw_const(8'h40),      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    repeat (2) @(posedge clk);
    #1;
    check("reset_vld", int'(convResVld), 0);
    check("reset_busy", int'(busy), 0);
    check_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      start_tile($sformatf("vec%0d", v), vecs[v].im, vecs[v].iw);
      check_outs($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4);
      hold($sformatf("vec%0d_hold", v), 2, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4);
      release_vld($sformatf("vec%0d", v), 1'b1);
      repeat (3) @(negedge clk);
    end

    // Long hold, release with iwVld kept high, then re-capture a new tile.
    start_tile("seqA", im_const(8'h40), iw_const(8'h08));
    check_outs("seqA_first", 16'h1900, 16'h1900, 16'h1900, 16'h1900);
    hold("seqA_hold", 10, 16'h1900, 16'h1900, 16'h1900, 16'h1900);
    release_vld("seqA", 1'b0);
    @(negedge clk);
    start_tile("seqA_recap", im_ramp(), iw_const(8'h08));
    check_outs("seqA_recap", 16'h0578, 16'h05DC, 16'h07D0, 16'h0834);
    @(negedge clk) iwVld = 1'b0;
    hold("seqA_iw_drop", 3, 16'h0578, 16'h05DC, 16'h07D0, 16'h0834);
    release_vld("seqA_end", 1'b1);
    repeat (3) @(negedge clk);

    // Abort at tap 10: no result, previous outputs retained.
    begin_tile(im_const(8'h40), iw_const(8'h40));
    repeat (10) @(posedge clk);
    @(negedge clk) imVld = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (convResVld) seen = 1'b1;
    end
    check("abort_no_vld", int'(seen), 0);
    check("abort_busy", int'(busy), 0);
    check_outs("abort_kept", 16'h0578, 16'h05DC, 16'h07D0, 16'h0834);
    @(negedge clk) iwVld = 1'b0;
    repeat (2) @(negedge clk);

    // Reset at tap 10, then a full handshake.
    begin_tile(im_ramp(), iw_single(12, 8'h40));
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_vld", int'(convResVld), 0);
    check("rst_mid_busy", int'(busy), 0);
    check_outs("rst_mid", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    imVld = 1'b0; iwVld = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    start_tile("rst_after", im_ramp(), iw_single(12, 8'h40));
    check_outs("rst_after", 16'h01C0, 16'h01E0, 16'h0280, 16'h02A0);
    release_vld("rst_after", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
